// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART host driver.
// Holds the FSM state enum, framing constants and a clog2 helper.
package uart_host_pkg;

  localparam int   BitsPerByte = 8;
  localparam logic IdleLevel   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_CTS,
    TX_START,
    TX_BITS,
    TX_STOP,
    RX_WAIT,
    RX_START,
    RX_BITS,
    RX_STOP,
    RSP
  } state_e;

  // Never returns less than 1 so it is safe as a vector width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_host_baud_counter.sv
// Shared baud timer: tick every ClocksPerBaud cycles, half_tick at the
// start-bit midpoint. Ports: clk, rst, restart in; tick, half_tick out.
module uart_host_baud_counter
  import uart_host_pkg::*;
#(
  parameter int ClocksPerBaud = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic half_tick
);

  localparam int W = clog2(ClocksPerBaud);
  localparam logic [W-1:0] Last = W'(ClocksPerBaud - 1);
  localparam logic [W-1:0] Half = W'(ClocksPerBaud / 2 - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == Last) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick      = (cnt_q == Last);
  assign half_tick = (cnt_q == Half);

endmodule

// File: rtl/uart_host_driver.sv
// Host-side UART link driver: serializes req_data as 8N1 frames on tx_out
// gated by cts_in_n, deserializes replies from rx_in into rsp_data.
// Ports: clk, rst, req_*, rsp_*, tx_out, rx_in, cts_in_n, framing_error;
// timeout port only with UART_HOST_DRIVER_TIMEOUT_EN defined.
module uart_host_driver
  import uart_host_pkg::*;
#(
  parameter int ClocksPerBaud = 8,
  parameter int InputBytes    = 1,
  parameter int OutputBytes   = 1,
  parameter int TimeoutClocks = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*InputBytes-1:0]   req_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  output logic [8*OutputBytes-1:0]  rsp_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      tx_out,
  input  logic                      rx_in,
  input  logic                      cts_in_n,
  output logic                      framing_error
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam int MaxBytes =
    (InputBytes > OutputBytes) ? InputBytes : OutputBytes;
  localparam int CW = clog2(MaxBytes + 1);
  localparam logic [CW-1:0] InLast  = CW'(InputBytes - 1);
  localparam logic [CW-1:0] OutLast = CW'(OutputBytes - 1);

  state_e                   state_q, state_d;
  logic [8*InputBytes-1:0]  req_q, req_d;
  logic [8*OutputBytes-1:0] rsp_q, rsp_d;
  logic [CW-1:0]            byte_q, byte_d;
  logic [2:0]               bit_q, bit_d;
  logic [7:0]               rxb_q, rxb_d;
  logic                     fe_q, fe_d;
  logic                     tx_q, tx_d;
  logic                     rx1_q, rx1_d;
  logic                     rx2_q, rx2_d;
  logic                     tick, half_tick;
  logic                     rx_s;

`ifdef UART_HOST_DRIVER_TIMEOUT_EN
  localparam int TW = clog2(TimeoutClocks + 1);
  localparam logic [TW-1:0] ToLast = TW'(TimeoutClocks - 1);
  logic [TW-1:0] to_q, to_d;
  logic          tmo_q, tmo_d;
`endif

  assign rx_s = rx2_q;

  uart_host_baud_counter #(
    .ClocksPerBaud(ClocksPerBaud)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (state_d != state_q),
    .tick     (tick),
    .half_tick(half_tick)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    rxb_d   = rxb_q;
    fe_d    = fe_q;
    tx_d    = IdleLevel;
    rx1_d   = rx_in;
    rx2_d   = rx1_q;
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
    to_d    = '0;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = req_data;
          rsp_d   = '0;
          byte_d  = '0;
          fe_d    = 1'b0;
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
          state_d = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        if (!cts_in_n) state_d = TX_START;
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = TX_BITS;
        end
      end
      TX_BITS: begin
        // req_q shifts out LSB first, so the next byte ends up in [7:0]
        tx_d = req_q[0];
        if (tick) begin
          req_d = req_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (byte_q == InLast) begin
            byte_d  = '0;
            state_d = RX_WAIT;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = WAIT_CTS;
          end
        end
      end
      RX_WAIT: begin
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
        to_d = to_q + 1'b1;
        if (to_q == ToLast) begin
          tmo_d   = 1'b1;
          state_d = RSP;
        end else if (!rx_s) begin
          state_d = RX_START;
        end
`else
        if (!rx_s) state_d = RX_START;
`endif
      end
      RX_START: begin
        if (half_tick) begin
          bit_d   = '0;
          state_d = rx_s ? RX_WAIT : RX_BITS;
        end
      end
      RX_BITS: begin
        if (tick) begin
          rxb_d = {rx_s, rxb_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (!rx_s) fe_d = 1'b1;
          for (int i = 0; i < OutputBytes; i++) begin
            if (byte_q == CW'(i))
              rsp_d[i*BitsPerByte +: BitsPerByte] = rxb_q;
          end
          if (byte_q == OutLast) begin
            state_d = RSP;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = RX_WAIT;
          end
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      rxb_q   <= '0;
      fe_q    <= 1'b0;
      tx_q    <= IdleLevel;
      rx1_q   <= IdleLevel;
      rx2_q   <= IdleLevel;
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
      to_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      rxb_q   <= rxb_d;
      fe_q    <= fe_d;
      tx_q    <= tx_d;
      rx1_q   <= rx1_d;
      rx2_q   <= rx2_d;
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
      to_q    <= to_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign tx_out        = tx_q;
  assign rsp_data      = rsp_q;
  assign framing_error = fe_q;
  assign req_ready     = (state_q == IDLE) && !rst;
  assign rsp_valid     = (state_q == RSP) && !rst;
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
  assign timeout       = tmo_q;
`endif

endmodule

// File: tb/tb_uart_host_driver.sv
// Directed bench for uart_host_driver with a UART device model.
// Two-byte request/response build, ClocksPerBaud = 8.
module tb_uart_host_driver;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_data;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        tx_out;
  logic        rx_in;
  logic        cts_in_n;
  logic        framing_error;
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_host_driver #(
    .ClocksPerBaud(CPB),
    .InputBytes   (2),
    .OutputBytes  (2),
    .TimeoutClocks(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .tx_out       (tx_out),
    .rx_in        (rx_in),
    .cts_in_n     (cts_in_n),
    .framing_error(framing_error)
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
    ,
    .timeout      (timeout)
`endif
  );

  typedef struct {
    logic [15:0] req;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    logic [7:0]  r0;
    logic [7:0]  r1;
    bit          s0;
    bit          s1;
    logic [15:0] rsp;
    bit          fe;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Waits for req_ready, then offers the request for exactly one edge.
  task automatic do_req(input logic [15:0] d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    check("req_ready_seen", 32'(ok), 32'd1);
    req_data  = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Decodes one frame from tx_out, sampling at mid-bit.
  task automatic get_byte(output logic [7:0] b, output bit stop);
    bit got;
    got  = 0;
    b    = '0;
    stop = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_out === 1'b0) begin
        got = 1;
        break;
      end
    end
    check("tx_start_seen", 32'(got), 32'd1);
    if (got) begin
      repeat (CPB / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        b[j] = tx_out;
      end
      repeat (CPB) @(negedge clk);
      stop = tx_out;
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input bit stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx_in = b[j];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_rsp(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("rsp_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] b0, b1;
    bit         st0, st1;
    int         bad;

    vecs[0] = '{16'h0001, 8'h01, 8'h00, 8'h02, 8'h00,
                1, 1, 16'h0002, 0};
    vecs[1] = '{16'hA50F, 8'h0F, 8'hA5, 8'h10, 8'hA6,
                1, 1, 16'hA610, 0};
    vecs[2] = '{16'h0055, 8'h55, 8'h00, 8'h56, 8'h00,
                1, 1, 16'h0056, 0};
    vecs[3] = '{16'hFF00, 8'h00, 8'hFF, 8'h3C, 8'hC3,
                1, 0, 16'hC33C, 1};
    vecs[4] = '{16'h1234, 8'h34, 8'h12, 8'hFF, 8'h01,
                1, 1, 16'h01FF, 0};

    rst       = 1'b1;
    req_data  = '0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rx_in     = 1'b1;
    cts_in_n  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_framing", 32'(framing_error), 32'd0);
`ifdef UART_HOST_DRIVER_TIMEOUT_EN
    check("rst_timeout", 32'(timeout), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // CTS hold-off, start latency, then reset mid TX_BITS
    cts_in_n = 1'b1;
    do_req(16'h0000);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1) bad++;
    end
    check("cts_hold_idle", 32'(bad), 32'd0);
    cts_in_n = 1'b0;
    @(negedge clk);
    check("cts_lat_1", 32'(tx_out), 32'd1);
    @(negedge clk);
    check("cts_lat_2", 32'(tx_out), 32'd0);
    repeat (3 * CPB) @(negedge clk);
    check("tx_low_mid_bits", 32'(tx_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_tx_out", 32'(tx_out), 32'd1);
    check("rst_mid_req_ready1", 32'(req_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);

    // Table-driven transactions
    for (int v = 0; v < 5; v++) begin
      do_req(vecs[v].req);
      get_byte(b0, st0);
      get_byte(b1, st1);
      check($sformatf("v%0d_tx0", v), 32'(b0), 32'(vecs[v].tx0));
      check($sformatf("v%0d_tx1", v), 32'(b1), 32'(vecs[v].tx1));
      check($sformatf("v%0d_stop", v), 32'({st1, st0}), 32'd3);
      repeat (2 * CPB) @(negedge clk);
      put_byte(vecs[v].r0, vecs[v].s0);
      put_byte(vecs[v].r1, vecs[v].s1);
      wait_rsp(200);
      check($sformatf("v%0d_rsp", v), 32'(rsp_data), 32'(vecs[v].rsp));
      check($sformatf("v%0d_fe", v), 32'(framing_error), 32'(vecs[v].fe));
      ack_rsp();
    end

    // Short low pulse in RX_WAIT is rejected as a glitch
    do_req(16'h0000);
    get_byte(b0, st0);
    get_byte(b1, st1);
    repeat (2 * CPB) @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (12) @(negedge clk);
    put_byte(8'h3C, 1);
    put_byte(8'h00, 1);
    wait_rsp(200);
    check("glitch_rsp", 32'(rsp_data), 32'h003C);
    check("glitch_fe", 32'(framing_error), 32'd0);
    ack_rsp();

`ifdef UART_HOST_DRIVER_TIMEOUT_EN
    // No reply: watchdog presents an empty response
    do_req(16'h00FF);
    wait_rsp(600);
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_rsp_data", 32'(rsp_data), 32'd0);
    ack_rsp();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_host_driver.md
Name: uart_host_driver

Overview:
- Host-side counterpart of the ice40 io_wrapper UART link, synthesizable so it can drive a DUT in-fabric and serve as a reusable bench stimulus engine.
- Takes a flat request vector, serializes it LSB-byte-first as 8N1 UART frames on tx_out, and honours the device's active-low clear-to-send.
- Deserializes the device's response frames from rx_in into a flat response vector with valid/ready output.

Parameters:
- ClocksPerBaud, 8, clk cycles per UART bit; must be >= 4.
- InputBytes, 1, request bytes per transaction; must be >= 1.
- OutputBytes, 1, response bytes per transaction; must be >= 1.
- TimeoutClocks, 4096, response watchdog limit; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_data  input  8*InputBytes  request vector; byte 0 = bits [7:0], sent first
- req_valid  input  1  request offered
- req_ready  output  1  request accepted when valid && ready
- rsp_data  output  8*OutputBytes  response vector; first received byte lands in [7:0]
- rsp_valid  output  1  response held until accepted
- rsp_ready  input  1  consumer accepts
- tx_out  output  1  UART line to device; idle high
- rx_in  input  1  UART line from device; asynchronous to clk
- cts_in_n  input  1  device clear-to-send, active-low
- framing_error  output  1  sticky; cleared by rst or by the next request acceptance

Behaviour:
- Reset values: tx_out=1, req_ready=0, rsp_valid=0, rsp_data=0, framing_error=0. Internal state returns to IDLE and counters clear.
- Reset mid-frame aborts the frame immediately. tx_out is high on the first cycle after rst deasserts.
- rx_in passes through a 2-flop synchronizer. All rx timing below counts from the synchronized value.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid && req_ready: latch req_data, clear the byte index, clear framing_error, go to WAIT_CTS.
- WAIT_CTS:
  - Sample cts_in_n each cycle.
  - When it reads 0, go to TX_START on the next cycle.
  - CTS is checked only before each byte. Deassertion mid-frame does not interrupt the frame.
- TX_START:
  - tx_out=0 for exactly ClocksPerBaud cycles.
- TX_BITS:
  - 8 data bits, LSB first, each held ClocksPerBaud cycles.
- TX_STOP:
  - tx_out=1 for ClocksPerBaud cycles.
  - Then increment the byte index. If index==InputBytes go to RX_WAIT, else go to WAIT_CTS.
- RX_WAIT:
  - Wait for synchronized rx_in==0, then go to RX_START.
  - Falling edges seen before RX_WAIT are ignored; the device does not reply before the request completes.
- RX_START:
  - Count ClocksPerBaud/2 cycles (integer floor), then resample.
  - If rx still 0, go to RX_BITS.
  - Else treat as a glitch and return to RX_WAIT; no error.
- RX_BITS:
  - Sample every ClocksPerBaud cycles at mid-bit.
  - Shift the 8 samples LSB first into the current byte slot of rsp_data.
- RX_STOP:
  - Sample one more mid-bit. If 0, set framing_error; the byte is kept regardless.
  - If received count==OutputBytes go to RSP, else go to RX_WAIT.
- RSP:
  - rsp_valid=1 with rsp_data stable.
  - On rsp_ready, go to IDLE with rsp_valid=0.
  - rsp_valid and req_ready are never high in the same cycle.
- Handshake latency:
  - Request accept to first tx_out falling edge: 2 cycles when cts_in_n is already 0.
  - Last stop-bit sample to rsp_valid: 1 cycle.
- Counters:
  - Baud counter width is clog2(ClocksPerBaud); it wraps at ClocksPerBaud-1.
  - Byte counters are sized clog2(max(InputBytes, OutputBytes)+1).
  - No wrap past InputBytes or OutputBytes.

Optional Feature:
- Macro: UART_HOST_DRIVER_TIMEOUT_EN.
- Defined:
  - Adds output port timeout (1 bit, reset 0).
  - A counter runs in RX_WAIT and restarts on each entry to RX_WAIT.
  - Reaching TimeoutClocks drives timeout=1 for the rest of the transaction and moves the FSM to RSP, presenting the partial rsp_data (unreceived bytes zero).
  - timeout clears on the next request acceptance.
- Undefined: no timeout port and no counter; RX_WAIT waits indefinitely.

Decomposition:
- Package uart_host_pkg holds:
  - the FSM state enum (IDLE, WAIT_CTS, TX_START, TX_BITS, TX_STOP, RX_WAIT, RX_START, RX_BITS, RX_STOP, RSP);
  - localparams BitsPerByte=8 and IdleLevel=1;
  - the clog2 helper function.
- Sub-module uart_host_baud_counter provides the shared baud tick plus a half-period start-bit tick, with a synchronous restart input. Tx and rx phases never overlap, so the FSM uses one instance.

Test Plan:
- Loopback with an io_wrapper add1 DUT, ClocksPerBaud=8, request 0x55 → tx frame is 0, then 1,0,1,0,1,0,1,0, then 1 (160 ticks at 2 ticks/clk); rsp_data=0x56; framing_error=0.
- cts_in_n held 1 for 100 cycles after acceptance → tx_out stays 1 throughout; first start bit begins 2 cycles after cts_in_n falls.
- InputBytes=2, OutputBytes=2, request 0xA50F → bytes sent as 0x0F then 0xA5; bench replies 0x10, 0xA6 → rsp_data=0xA610.
- rx_in low pulse of 3 cycles in RX_WAIT (ClocksPerBaud=8), then a valid frame 0x3C → glitch rejected, rsp_data=0x3C; stop bit forced 0 → framing_error=1 with byte retained.
- rst asserted mid TX_BITS → next cycle tx_out=1, req_ready=1, rsp_valid=0; a subsequent request 0x01 completes normally.
- With UART_HOST_DRIVER_TIMEOUT_EN, TimeoutClocks=64, no device reply → timeout=1 and rsp_valid=1 at cycle 64 after entering RX_WAIT, rsp_data=0.
